// File: rtl/solitaire_pkg.sv
// Shared card encoding, pile geometry and deal-FSM state encoding.
package solitaire_pkg;

    // Card layout: {rank[3:0], suit[1:0], face_up}
    localparam int CARD_W      = 7;
    localparam int FACE_UP_BIT = 0;
    localparam int SUIT_LSB    = 1;
    localparam int SUIT_MSB    = 2;
    localparam int RANK_LSB    = 3;
    localparam int RANK_MSB    = 6;

    localparam logic [1:0] SUIT_CLUBS    = 2'd0;
    localparam logic [1:0] SUIT_DIAMONDS = 2'd1;
    localparam logic [1:0] SUIT_HEARTS   = 2'd2;
    localparam logic [1:0] SUIT_SPADES   = 2'd3;

    localparam logic [CARD_W-1:0] EMPTY_CARD = 7'h00;

    localparam int NUM_TAB     = 7;
    localparam int TAB_DEPTH   = 19;
    localparam int STOCK_DEPTH = 24;
    localparam int DECK_SIZE   = 52;

    // Deck index of the last card, and the count of cards that go to the tableaux.
    localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);
    localparam logic [5:0] TAB_CARDS = 6'd28;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHUFFLE = 3'd2,
        ST_DEAL    = 3'd3,
        ST_DONE    = 3'd4
    } deal_state_t;

    // Card at position k of a freshly sorted deck, face-down.
    function automatic logic [CARD_W-1:0] sorted_card(input logic [5:0] k);
        logic [3:0] rank;
        logic [1:0] suit;
        rank = 4'(k % 6'd13) + 4'd1;
        suit = 2'(k / 6'd13);
        return {rank, suit, 1'b0};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; a zero seed is replaced by the default
// so the register can never lock up at 0.
module lfsr16 #(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter logic [15:0] TAPS         = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    // Load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (en) begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/deal_cards.sv
// Builds a sorted deck, optionally Fisher-Yates shuffles it, and deals the
// Klondike layout into seven tableau vectors and a stock vector.
// Output protocol: deal_valid is a level with no ready; the consumer may read
// the piles on any cycle deal_valid is high. The piles stay stable until the
// edge that accepts the next start, where deal_valid and the piles clear together.
module deal_cards
    import solitaire_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              shuffle_en,
    input  logic [15:0]                       seed,
    output logic                              busy,
    output logic                              done,
    output logic                              deal_valid,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau1,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau2,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau3,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau4,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau5,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau6,
    output logic [TAB_DEPTH*CARD_W-1:0]       tableau7,
    output logic [STOCK_DEPTH*CARD_W-1:0]     stock_pile,
    output deal_state_t                       fsm_state
);

    deal_state_t state, next_state;

    logic [5:0]  idx;        // INIT: write slot, SHUFFLE: i, DEAL: p
    logic [2:0]  row;        // tableau row being dealt
    logic [2:0]  tab;        // zero-based tableau receiving the next card
    logic        shuf_q;
    logic        done_q;
    logic        accept;
    logic        lfsr_en;
    logic        swap;
    logic [15:0] lfsr_q;
    logic [5:0]  j;
    logic        unused_lfsr_hi;
    logic [CARD_W-2:0] deal_face;

    logic [CARD_W-1:0]                   deck [DECK_SIZE];
    logic [TAB_DEPTH-1:0][CARD_W-1:0]    tab_q [NUM_TAB];
    logic [STOCK_DEPTH-1:0][CARD_W-1:0]  stock_q;

    assign j              = lfsr_q[5:0];
    assign unused_lfsr_hi = ^lfsr_q[15:6];
    assign deal_face      = deck[idx][CARD_W-1:1];

    lfsr16 #(
        .DEFAULT_SEED (DEFAULT_SEED),
        .TAPS         (16'hB400)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (seed),
        .en   (lfsr_en),
        .q    (lfsr_q)
    );

    // State register and the one-cycle done pulse on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (next_state == ST_DONE) && (state != ST_DONE);
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        lfsr_en    = 1'b0;
        swap       = 1'b0;
        busy       = 1'b0;
        deal_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_INIT;
                end
            end
            ST_DONE: begin
                deal_valid = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = shuf_q ? ST_SHUFFLE : ST_DEAL;
                end
            end
            ST_SHUFFLE: begin
                busy    = 1'b1;
                lfsr_en = 1'b1;
                // Out-of-range candidates are simply rejected; the LFSR keeps stepping.
                if (j <= idx) begin
                    swap = 1'b1;
                    if (idx == 6'd1) begin
                        next_state = ST_DEAL;
                    end
                end
            end
            ST_DEAL: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Shared index plus the row/tableau walk used while dealing.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= 6'd0;
            row    <= 3'd0;
            tab    <= 3'd0;
            shuf_q <= 1'b0;
        end else if (accept) begin
            idx    <= 6'd0;
            row    <= 3'd0;
            tab    <= 3'd0;
            shuf_q <= shuffle_en;
        end else begin
            case (state)
                ST_INIT: begin
                    if (idx == LAST_IDX) begin
                        idx <= shuf_q ? LAST_IDX : 6'd0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                ST_SHUFFLE: begin
                    if (swap) begin
                        idx <= (idx == 6'd1) ? 6'd0 : idx - 6'd1;
                    end
                end
                ST_DEAL: begin
                    if (idx != LAST_IDX) begin
                        idx <= idx + 6'd1;
                    end
                    if (idx < TAB_CARDS) begin
                        if (tab == 3'd6) begin
                            row <= row + 3'd1;
                            tab <= row + 3'd1;
                        end else begin
                            tab <= tab + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Deck storage: sequential fill during INIT, in-place swaps during SHUFFLE.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            deck[idx] <= sorted_card(idx);
        end else if (swap) begin
            deck[idx] <= deck[j];
            deck[j]   <= deck[idx];
        end
    end

    // Pile registers: cleared on reset and on a new start, filled one card per DEAL cycle.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            for (int t = 0; t < NUM_TAB; t++) begin
                tab_q[t] <= '0;
            end
            stock_q <= '0;
        end else if (state == ST_DEAL) begin
            if (idx < TAB_CARDS) begin
                // Only the last card of each tableau (row == tableau index) is face-up.
                tab_q[tab][{2'b00, row}] <= {deal_face, (row == tab)};
            end else begin
                stock_q[5'(idx - TAB_CARDS)] <= {deal_face, 1'b0};
            end
        end
    end

    assign done       = done_q;
    assign fsm_state  = state;
    assign tableau1   = tab_q[0];
    assign tableau2   = tab_q[1];
    assign tableau3   = tab_q[2];
    assign tableau4   = tab_q[3];
    assign tableau5   = tab_q[4];
    assign tableau6   = tab_q[5];
    assign tableau7   = tab_q[6];
    assign stock_pile = stock_q;

endmodule

// File: doc/deal_cards.md
# deal_cards

Game-setup stage directly upstream of the card-move logic. On `start` it builds a sorted 52-card deck, shuffles it in place with an LFSR-driven Fisher–Yates pass, and deals the standard Klondike layout. The layout is seven tableau piles, tableau n holding n cards with only the top one face-up, and the remaining 24 cards face-down in the stock. The move stage consumes the resulting flat pile vectors once `deal_valid` is high.

## Interface
- `DEFAULT_SEED`, 16'hACE1: LFSR value after reset; also substituted whenever `seed` == 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new deal; sampled only in IDLE or DONE.
- `shuffle_en` in 1: when 0, the SHUFFLE state is skipped and a sorted deck is dealt; sampled with `start`.
- `seed` in 16: loaded into the LFSR when `start` is accepted.
- `busy` out 1: high in INIT, SHUFFLE and DEAL.
- `done` out 1: one-cycle pulse on entry to DONE.
- `deal_valid` out 1: level, high while in DONE.
- `tableau1`…`tableau7` out 19*7 each: slot k occupies bits [k*7+6:k*7]; slot 0 is the bottom card.
- `stock_pile` out 24*7: same slot layout; slot 0 is the bottom card.

## Operation
- Card encoding (7 bits):
  - bit0: face-up.
  - [2:1]: suit (0 clubs, 1 diamonds, 2 hearts, 3 spades).
  - [6:3]: rank 1..13.
  - 7'h00: empty slot.
- Internal deck: 52×7 register array with combinational reads; index p.
- States: IDLE → INIT → (SHUFFLE if `shuffle_en`) → DEAL → DONE.
  - IDLE/DONE + `start`:
    - Clear all pile outputs to 0.
    - Load LFSR.
    - Latch `shuffle_en`.
    - Go to INIT.
  - INIT: 52 cycles. Cycle k writes `deck[k]` = {rank = k%13+1, suit = k/13, face-down}.
  - SHUFFLE:
    - i starts at 51. The LFSR advances every cycle. Candidate j = lfsr[5:0].
    - If j ≤ i: swap `deck[i]` and `deck[j]` (j == i is a no-op swap), then i ← i−1. Otherwise wait.
    - Exit to DEAL after the swap at i = 1.
  - DEAL: 52 cycles, one card per cycle.
    - p = 0..27: row-major deal. For row r = 0..6, for tableau t = r+1..7, `deck[p]` goes to tableau t slot r. bit0 is set iff r == t−1.
    - p = 28..51: `deck[p]` goes to `stock_pile` slot p−28, face-down.
  - DONE: outputs hold until the next accepted `start` or `rst`.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right. It never holds 0.
- `start` during `busy` is ignored; the deal in progress is unaffected.
- Unused tableau slots (index ≥ n) remain 7'h00.

## Timing
- Reset values:
  - state IDLE; all pile outputs 0.
  - `busy`, `done` and `deal_valid` 0.
  - LFSR = `DEFAULT_SEED`.
  - deck contents don't-care; INIT rewrites the deck before any use.
- `rst` mid-deal aborts immediately and takes precedence over `start` in the same cycle.
- Unshuffled latency: with `start` sampled at edge E0, `done`/`deal_valid` are visible after edge E104 (52 INIT + 52 DEAL).
- `deal_valid` and pile outputs drop to 0 at the edge that accepts a new `start`.
- Shuffled latency: 104 cycles plus a variable SHUFFLE time. Candidates are 6 bits, so each step accepts with probability ≥ 2/64. Expected SHUFFLE time is a few hundred cycles; there is no fixed bound.
- `busy` is high from the edge after start acceptance through the final DEAL cycle.

## Structure
- Shared `solitaire_pkg`:
  - `CARD_W` = 7.
  - Face-up, suit and rank field positions.
  - Suit constants.
  - `EMPTY_CARD`.
  - Tableau depth 19, stock depth 24, deck size 52.
  - State encoding.
- Sub-module `lfsr16`:
  - Ports: `clk`, `rst`, `load`, `seed`, `en`, `q`.
  - Performs the seed-0 substitution internally.

## Test plan
- Reset, then `start` with `shuffle_en`=0. Expect:
  - `done` after 105 edges.
  - `tableau1` slot0 = 7'h09.
  - `tableau7` slot0 = 7'h38.
  - `tableau2` slot1 = 7'h41.
  - `tableau7` slot6 = 7'h15.
  - `stock_pile` slot0 = 7'h1C, slot23 = 7'h6E.
  - All other tableau slots ≥ n are 0.
- `shuffle_en`=1, `seed`=16'h1234. Expect:
  - All 52 rank/suit pairs appear exactly once across the piles.
  - Exactly 7 cards are face-up, one at the top of each tableau.
  - Every stock card is face-down.
- `seed`=0 vs `seed`=16'hACE1: identical final layouts.
- Pulse `start` during SHUFFLE: ignored; the layout equals the uninterrupted run for the same seed.
- Assert `rst` at the 30th DEAL cycle: next cycle all outputs are 0 and the state is IDLE; a fresh `start` completes normally.
- Second `start` from DONE: `deal_valid` drops the next cycle, piles clear, and a new deal completes.
